// File: rtl/tnn_pkg.sv
// Shared types and defaults for the ternary-network vote accumulator.
package tnn_pkg;

  localparam int NUM_CLASSES_DEF = 7;
  localparam int NODES_PER_CLASS_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int CLS_W = 3;

  typedef enum logic [1:0] {
    ACC,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/tnn_argmax_step.sv
// One argmax step: fold a class count into the running best.
module tnn_argmax_step
  import tnn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             first,
  input  logic [CNT_W-1:0] best,
  input  logic [CLS_W-1:0] best_idx,
  input  logic             tie,
  input  logic [CNT_W-1:0] cur,
  input  logic [CLS_W-1:0] cur_idx,
  output logic [CNT_W-1:0] best_next,
  output logic [CLS_W-1:0] idx_next,
  output logic             tie_next
);

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    best_next = best;
    idx_next = best_idx;
    tie_next = tie;
    if (first || cur > best) begin
      best_next = cur;
      idx_next = cur_idx;
      tie_next = 1'b0;
    end else if (cur == best) begin
      tie_next = 1'b1;
    end
  end

endmodule

// File: rtl/tnn_vote_accum.sv
// Counts comparator votes per class, then scans for the winning class.
module tnn_vote_accum
  import tnn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int NODES_PER_CLASS = NODES_PER_CLASS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_vote,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_class,
  output logic [CNT_W-1:0] out_score,
  output logic             out_tie,
  output logic             err
);

  localparam int NODE_W =
    (NODES_PER_CLASS > 1) ? $clog2(NODES_PER_CLASS) : 1;
  localparam int SCAN_W = $clog2(NUM_CLASSES + 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  cnt [NUM_CLASSES];
  logic [CLS_W-1:0]  cls;
  logic [NODE_W-1:0] node;
  logic [SCAN_W-1:0] si;
  logic [CNT_W-1:0]  best;
  logic [CLS_W-1:0]  best_idx;
  logic              tie;

  logic [CNT_W-1:0]  best_next;
  logic [CLS_W-1:0]  idx_next;
  logic              tie_next;

  logic accept;
  logic final_vote;
  logic node_wrap;
  logic frame_end;
  logic scan_done;
  logic handoff;

  assign accept = in_valid && in_ready;
  assign node_wrap = node == NODE_W'(NODES_PER_CLASS - 1);
  assign final_vote =
    node_wrap && cls == CLS_W'(NUM_CLASSES - 1);
  assign frame_end = accept && (in_last || final_vote);
  assign scan_done = si == SCAN_W'(NUM_CLASSES);
  assign handoff = out_valid && out_ready;

  tnn_argmax_step #(
    .CNT_W(CNT_W)
  ) u_step (
    .first    (si == '0),
    .best     (best),
    .best_idx (best_idx),
    .tie      (tie),
    .cur      (cnt[si]),
    .cur_idx  (CLS_W'(si)),
    .best_next(best_next),
    .idx_next (idx_next),
    .tie_next (tie_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACC:  if (frame_end) state_next = SCAN;
      SCAN: if (scan_done) state_next = DONE;
      DONE: if (handoff) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_comb begin
    in_ready = state == ACC;
    out_valid = state == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      cls <= '0;
      node <= '0;
      si <= '0;
      best <= '0;
      best_idx <= '0;
      tie <= 1'b0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        if (in_vote && cnt[cls] != '1)
          cnt[cls] <= cnt[cls] + CNT_W'(1);
        if (in_last != final_vote) err <= 1'b1;
        if (frame_end) begin
          si <= '0;
        end else if (node_wrap) begin
          node <= '0;
          cls <= cls + CLS_W'(1);
        end else begin
          node <= node + NODE_W'(1);
        end
      end
      if (state == SCAN && !scan_done) begin
        best <= best_next;
        best_idx <= idx_next;
        tie <= tie_next;
        si <= si + SCAN_W'(1);
      end
      // Result is consumed: start the next frame from index 0.
      if (handoff) begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        cls <= '0;
        node <= '0;
      end
    end
  end

  assign out_class = best_idx;
  assign out_score = best;
  assign out_tie = tie;

endmodule

// File: tb/tb_tnn_vote_accum.sv
// Directed bench for tnn_vote_accum.
module tb_tnn_vote_accum;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_vote;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [3:0] out_score;
  logic       out_tie;
  logic       err;

  int checks;
  int errors;

  tnn_vote_accum dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vote  (in_vote),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_score(out_score),
    .out_tie  (out_tie),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] pat(
    input int c0, input int c1, input int c2, input int c3,
    input int c4, input int c5, input int c6);
    int c[7];
    logic [55:0] r;
    c = '{c0, c1, c2, c3, c4, c5, c6};
    r = '0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 8; j++)
        if (j < c[i]) r[i*8+j] = 1'b1;
    return r;
  endfunction

  task automatic run_frame(input logic [55:0] v, input int last_at,
                           input bit use_last, input bit gaps);
    for (int k = 0; k <= last_at; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_vote = 1'b1;
          in_last = 1'b1;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_vote = v[k];
      in_last = use_last && (k == last_at);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_vote = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, out_class, out_score, out_tie, err}
        !== {1'b0, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outs got v=%b r=%b c=%0d s=%0d t=%b e=%b want 0 1 0 0 0 0",
               out_valid, in_ready, out_class, out_score, out_tie, err);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_class();
    int n;
    run_frame(pat(0, 0, 8, 0, 0, 0, 0), 55, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got %b want 0", in_ready);
    end
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL single_latency got %0d want 8", n);
    end
    checks++;
    if ({out_class, out_score, out_tie, err} !== {3'd2, 4'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_result got c=%0d s=%0d t=%b e=%b want 2 8 0 0",
               out_class, out_score, out_tie, err);
    end
    handshake();
  endtask

  task automatic test_tie(input bit gaps);
    int n;
    run_frame(pat(3, 5, 3, 3, 5, 3, 3), 55, 1'b1, gaps);
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL tie_latency gaps=%0d got %0d want 8", gaps, n);
    end
    checks++;
    if ({out_class, out_score, out_tie, err} !== {3'd1, 4'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tie_result gaps=%0d got c=%0d s=%0d t=%b e=%b want 1 5 1 0",
               gaps, out_class, out_score, out_tie, err);
    end
    handshake();
  endtask

  task automatic test_frame_errors();
    int n;
    pulse_reset();
    run_frame(pat(1, 2, 3, 4, 5, 6, 7), 55, 1'b0, 1'b0);
    wait_out(n);
    checks++;
    if ({n, out_class, out_score, err} !== {32'd8, 3'd6, 4'd7, 1'b1}) begin
      errors++;
      $display("FAIL nolast got n=%0d c=%0d s=%0d e=%b want 8 6 7 1",
               n, out_class, out_score, err);
    end
    handshake();
    pulse_reset();
    run_frame(pat(6, 0, 3, 0, 0, 0, 0), 20, 1'b1, 1'b0);
    wait_out(n);
    checks++;
    if ({n, out_class, out_score, out_tie, err}
        !== {32'd8, 3'd0, 4'd6, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL early_last got n=%0d c=%0d s=%0d t=%b e=%b want 8 0 6 0 1",
               n, out_class, out_score, out_tie, err);
    end
    handshake();
    run_frame(pat(0, 0, 0, 0, 0, 7, 0), 55, 1'b1, 1'b0);
    wait_out(n);
    checks++;
    if ({out_class, out_score, out_tie, err} !== {3'd5, 4'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL next_frame got c=%0d s=%0d t=%b e=%b want 5 7 0 1",
               out_class, out_score, out_tie, err);
    end
    handshake();
    pulse_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err);
    end
  endtask

  task automatic test_backpressure();
    int n;
    run_frame(pat(2, 4, 1, 0, 7, 3, 2), 55, 1'b1, 1'b0);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, out_class, out_score, out_tie}
          !== {1'b1, 1'b0, 3'd4, 4'd7, 1'b0}) begin
        errors++;
        $display("FAIL hold cyc=%0d got v=%b r=%b c=%0d s=%0d t=%b want 1 0 4 7 0",
                 i, out_valid, in_ready, out_class, out_score, out_tie);
      end
      @(posedge clk);
      #1;
    end
    handshake();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release got r=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_abort();
    int n;
    run_frame(pat(8, 8, 8, 8, 0, 0, 0), 29, 1'b0, 1'b0);
    pulse_reset();
    checks++;
    if ({in_ready, out_valid, err} !== 3'b100) begin
      errors++;
      $display("FAIL abort_state got r=%b v=%b e=%b want 1 0 0",
               in_ready, out_valid, err);
    end
    run_frame(pat(2, 2, 2, 2, 2, 2, 8), 55, 1'b1, 1'b0);
    wait_out(n);
    checks++;
    if ({out_class, out_score, out_tie, err} !== {3'd6, 4'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_result got c=%0d s=%0d t=%b e=%b want 6 8 0 0",
               out_class, out_score, out_tie, err);
    end
    handshake();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_vote = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_class();
    test_tie(1'b0);
    test_tie(1'b1);
    test_frame_errors();
    test_backpressure();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
